// File: rtl/tlk2711_axi_pkg.sv
// Shared AXI encodings and FSM state types for the TLK2711 AXI memory slave.
package tlk2711_axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {R_IDLE, R_BURST} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

  // A burst is "bad" when it is not FIXED/INCR or its size is not the full bus
  // width; such bursts still move data (as INCR) but answer SLVERR.
  function automatic logic burst_bad(input logic [1:0] burst,
                                     input logic [2:0] size,
                                     input logic [2:0] native_size);
    logic bad;
    case (burst)
      BURST_FIXED, BURST_INCR: bad = 1'b0;
      BURST_WRAP:              bad = 1'b1;
      default:                 bad = 1'b1;
    endcase
    return bad | (size != native_size);
  endfunction

endpackage

// File: rtl/tlk2711_bram_tdp.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read-first
// read port. Contents are never reset.
module tlk2711_bram_tdp #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 1024,
  localparam int AW = $clog2(DEPTH),
  localparam int NB = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [NB-1:0]         wbe,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-lane write; lanes with a clear enable keep their old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  // Registered read; output holds when re is low, old data on same-word write.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tlk2711_axi_mem_slave.sv
// AXI4 slave memory model: serves read bursts and absorbs write bursts from
// a single shared RAM, with independent read and write FSMs.
module tlk2711_axi_mem_slave
  import tlk2711_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [31:0]             o_rd_bursts,
  output logic [31:0]             o_wr_bursts
);

  localparam int OFF = $clog2(DATA_WIDTH / 8);
  localparam int MW  = $clog2(MEM_DEPTH);
  localparam logic [2:0] NATIVE_SIZE = 3'(OFF);

  rd_state_t r_state;
  wr_state_t w_state;
  logic [7:0]    r_left, w_len, w_cnt;
  logic [MW-1:0] r_word, w_word;
  logic          r_fixed, w_fixed, w_err;

  // Address bits outside the word index are intentionally ignored (no decode).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_araddr, s_axi_awaddr};

  logic ar_fire, r_fire, aw_fire, w_fire, ar_bad, aw_bad, w_last_beat;
  logic [MW-1:0] ar_word, aw_word, r_word_next, w_word_next;
  logic          ram_re;
  logic [MW-1:0] ram_raddr;

  assign ar_fire     = s_axi_arvalid & s_axi_arready;
  assign r_fire      = s_axi_rvalid & s_axi_rready;
  assign aw_fire     = s_axi_awvalid & s_axi_awready;
  assign w_fire      = s_axi_wvalid & s_axi_wready;
  assign ar_word     = s_axi_araddr[OFF +: MW];
  assign aw_word     = s_axi_awaddr[OFF +: MW];
  assign ar_bad      = burst_bad(s_axi_arburst, s_axi_arsize, NATIVE_SIZE);
  assign aw_bad      = burst_bad(s_axi_awburst, s_axi_awsize, NATIVE_SIZE);
  assign r_word_next = r_fixed ? r_word : r_word + 1'b1;
  assign w_word_next = w_fixed ? w_word : w_word + 1'b1;
  assign w_last_beat = (w_cnt == w_len);

  // The RAM is read on AR acceptance and again on every non-final R handshake,
  // so the next beat is ready one cycle later and beats can stream.
  assign ram_re    = ar_fire | (r_fire & ~s_axi_rlast);
  assign ram_raddr = ar_fire ? ar_word : r_word_next;

  tlk2711_bram_tdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_fire),
    .waddr (w_word),
    .wbe   (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (s_axi_rdata)
  );

  // Read FSM: accept AR, stream arlen+1 beats, count completed bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      r_left        <= '0;
      r_word        <= '0;
      r_fixed       <= 1'b0;
      o_rd_bursts   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rid     <= s_axi_arid;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rresp   <= ar_bad ? RESP_SLVERR : RESP_OKAY;
            r_left        <= s_axi_arlen;
            r_word        <= ar_word;
            r_fixed       <= (s_axi_arburst == BURST_FIXED) & ~ar_bad;
            r_state       <= R_BURST;
          end
        end
        R_BURST: begin
          if (r_fire) begin
            if (s_axi_rlast) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              o_rd_bursts   <= o_rd_bursts + 32'd1;
              r_state       <= R_IDLE;
            end else begin
              r_left      <= r_left - 8'd1;
              s_axi_rlast <= (r_left == 8'd1);
              r_word      <= r_word_next;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: accept AW, absorb beats until wlast or awlen+1, then respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_word        <= '0;
      w_fixed       <= 1'b0;
      w_err         <= 1'b0;
      o_wr_bursts   <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_fire) begin
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            s_axi_bid     <= s_axi_awid;
            w_len         <= s_axi_awlen;
            w_cnt         <= '0;
            w_word        <= aw_word;
            w_fixed       <= (s_axi_awburst == BURST_FIXED) & ~aw_bad;
            w_err         <= aw_bad;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_word <= w_word_next;
            w_cnt  <= w_cnt + 8'd1;
            if (s_axi_wlast | w_last_beat) begin
              // wlast must coincide with the final counted beat
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bresp  <= (w_err | (s_axi_wlast ^ w_last_beat)) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bvalid & s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_awready <= 1'b1;
            o_wr_bursts   <= o_wr_bursts + 32'd1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlk2711_axi_mem_slave.sv
// Self-checking bench for tlk2711_axi_mem_slave: directed corner cases plus
// randomized bursts checked against a word-array memory model.
module tb_tlk2711_axi_mem_slave;

  localparam int AW = 40;
  localparam int DW = 128;
  localparam int IW = 4;
  localparam int DEPTH = 1024;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IW-1:0] s_axi_arid = '0, s_axi_awid = '0, s_axi_rid, s_axi_bid;
  logic [AW-1:0] s_axi_araddr = '0, s_axi_awaddr = '0;
  logic [7:0]    s_axi_arlen = '0, s_axi_awlen = '0;
  logic [2:0]    s_axi_arsize = '0, s_axi_awsize = '0;
  logic [1:0]    s_axi_arburst = '0, s_axi_awburst = '0, s_axi_rresp, s_axi_bresp;
  logic          s_axi_arvalid = 1'b0, s_axi_awvalid = 1'b0, s_axi_arready, s_axi_awready;
  logic [DW-1:0] s_axi_rdata, s_axi_wdata = '0;
  logic [NB-1:0] s_axi_wstrb = '0;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready = 1'b0;
  logic          s_axi_wlast = 1'b0, s_axi_wvalid = 1'b0, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready = 1'b0;
  logic [31:0]   o_rd_bursts, o_wr_bursts;

  tlk2711_axi_mem_slave #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .ID_WIDTH (IW), .MEM_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .s_axi_arid (s_axi_arid), .s_axi_araddr (s_axi_araddr), .s_axi_arlen (s_axi_arlen),
    .s_axi_arsize (s_axi_arsize), .s_axi_arburst (s_axi_arburst), .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready), .s_axi_rid (s_axi_rid), .s_axi_rdata (s_axi_rdata),
    .s_axi_rresp (s_axi_rresp), .s_axi_rlast (s_axi_rlast), .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready), .s_axi_awid (s_axi_awid), .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awlen (s_axi_awlen), .s_axi_awsize (s_axi_awsize), .s_axi_awburst (s_axi_awburst),
    .s_axi_awvalid (s_axi_awvalid), .s_axi_awready (s_axi_awready), .s_axi_wdata (s_axi_wdata),
    .s_axi_wstrb (s_axi_wstrb), .s_axi_wlast (s_axi_wlast), .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready), .s_axi_bid (s_axi_bid), .s_axi_bresp (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid), .s_axi_bready (s_axi_bready),
    .o_rd_bursts (o_rd_bursts), .o_wr_bursts (o_wr_bursts)
  );

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int ref_rd_bursts = 0;
  int ref_wr_bursts = 0;
  int n_checks = 0;
  int n_errors = 0;

  // Beat payloads for the next write burst
  logic [DW-1:0] wq_data [256];
  logic [NB-1:0] wq_strb [256];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [AW-1:0] a);
    return int'((a / NB) % DEPTH);
  endfunction

  function automatic bit is_err(input logic [1:0] burst, input logic [2:0] size);
    return !(burst == 2'd0 || burst == 2'd1) || (size != 3'd4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_payload(input int n, input bit full_strb);
    for (int i = 0; i < n; i++) begin
      wq_data[i] = {$urandom, $urandom, $urandom, $urandom};
      wq_strb[i] = full_strb ? '1 : NB'($urandom);
    end
  endtask

  // wlast_at: beat index carrying wlast (== len for a well-formed burst,
  // < len for early wlast, anything else for a missing wlast).
  task automatic axi_write(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                           input logic [2:0] size, input int wlast_at, input int bdelay,
                           input logic [IW-1:0] id, input bit gaps);
    int w, nbeats, t;
    bit err;
    logic [1:0] exp_resp;
    err = is_err(burst, size);
    w = word_of(addr);
    nbeats = (wlast_at >= 0 && wlast_at < len) ? wlast_at + 1 : len + 1;
    exp_resp = (err || wlast_at != len) ? 2'b10 : 2'b00;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awburst = burst; s_axi_awsize = size; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 50) begin tick(); t++; end
    if (!s_axi_awready) begin check("aw_timeout", 0, 1); s_axi_awvalid = 1'b0; return; end
    tick();
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin s_axi_wvalid = 1'b0; tick(); end
      s_axi_wdata = wq_data[i]; s_axi_wstrb = wq_strb[i];
      s_axi_wlast = (i == wlast_at); s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < 50) begin tick(); t++; end
      if (!s_axi_wready) begin
        check("w_timeout", 0, 1); s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; return;
      end
      tick();
      for (int b = 0; b < NB; b++)
        if (wq_strb[i][b]) ref_mem[w][b*8 +: 8] = wq_data[i][b*8 +: 8];
      if (burst != 2'd0 || err) w = (w + 1) % DEPTH;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin tick(); t++; end
    check("bvalid", s_axi_bvalid, 1);
    check("wready_after_last", s_axi_wready, 0);
    for (int d = 0; d < bdelay; d++) begin tick(); check("bvalid_hold", s_axi_bvalid, 1); end
    check("bid", s_axi_bid, id);
    check("bresp", s_axi_bresp, exp_resp);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    ref_wr_bursts++;
    check("bvalid_drop", s_axi_bvalid, 0);
    check("awready_back", s_axi_awready, 1);
    check("wr_bursts", o_wr_bursts, 32'(ref_wr_bursts));
    $display("WR id=%0d addr=%h len=%0d burst=%0d size=%0d beats=%0d bresp=%0d",
             id, addr, len, burst, size, nbeats, s_axi_bresp);
  endtask

  // mode 0: rready always 1; 1: rready 1010..; 2: random rready
  task automatic axi_read(input logic [AW-1:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int mode, input logic [IW-1:0] id);
    int w, beat, t;
    bit err, stalled;
    logic [DW-1:0] held;
    err = is_err(burst, size);
    w = word_of(addr);
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arburst = burst; s_axi_arsize = size; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin tick(); t++; end
    if (!s_axi_arready) begin check("ar_timeout", 0, 1); s_axi_arvalid = 1'b0; return; end
    tick();
    s_axi_arvalid = 1'b0;
    check("r_latency", s_axi_rvalid, 1);
    check("arready_busy", s_axi_arready, 0);
    beat = 0; t = 0; stalled = 1'b0; held = '0;
    while (beat <= len && t < 2000) begin
      case (mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = (t % 2 == 0);
        default: s_axi_rready = 1'($urandom);
      endcase
      if (stalled) check("rdata_stable", s_axi_rdata, held);
      stalled = 1'b0;
      if (s_axi_rvalid) begin
        if (s_axi_rready) begin
          check("rdata", s_axi_rdata, ref_mem[w]);
          check("rlast", s_axi_rlast, (beat == len));
          check("rresp", s_axi_rresp, err ? 2'b10 : 2'b00);
          check("rid", s_axi_rid, id);
          beat++;
          if (burst != 2'd0 || err) w = (w + 1) % DEPTH;
        end else begin
          held = s_axi_rdata;
          stalled = 1'b1;
        end
      end
      tick();
      t++;
    end
    s_axi_rready = 1'b0;
    if (beat <= len) begin check("r_timeout", 0, 1); return; end
    ref_rd_bursts++;
    check("rvalid_drop", s_axi_rvalid, 0);
    check("arready_back", s_axi_arready, 1);
    check("rd_bursts", o_rd_bursts, 32'(ref_rd_bursts));
    $display("RD id=%0d addr=%h len=%0d burst=%0d size=%0d mode=%0d", id, addr, len, burst, size, mode);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] all_ones;
    all_ones = '1;

    // Reset state
    repeat (3) tick();
    check("rst_arready", s_axi_arready, 1);
    check("rst_awready", s_axi_awready, 1);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rlast", s_axi_rlast, 0);
    check("rst_rresp", s_axi_rresp, 0);
    check("rst_bresp", s_axi_bresp, 0);
    check("rst_rd_bursts", o_rd_bursts, 0);
    check("rst_wr_bursts", o_wr_bursts, 0);
    rst_n = 1'b1;
    tick();

    // 1: simple INCR write/read at 0x100
    for (int i = 0; i < 4; i++) begin wq_data[i] = DW'(i); wq_strb[i] = '1; end
    axi_write(40'h100, 3, 2'd1, 3'd4, 3, 0, 4'd3, 1'b0);
    axi_read(40'h100, 3, 2'd1, 3'd4, 0, 4'd3);

    // Preload the whole RAM so every later read has a known expectation
    for (int k = 0; k < 4; k++) begin
      fill_payload(256, 1'b1);
      axi_write(40'(k * 256 * NB), 255, 2'd1, 3'd4, 255, 0, 4'(k), 1'b0);
    end

    // 2: 16-beat read with rready toggling
    axi_read(40'h2000, 15, 2'd1, 3'd4, 1, 4'd5);

    // 3: partial strobe over an all-ones word
    wq_data[0] = all_ones; wq_strb[0] = '1;
    axi_write(40'h500, 0, 2'd1, 3'd4, 0, 0, 4'd6, 1'b0);
    fill_payload(1, 1'b1);
    wq_strb[0] = 16'h000F;
    axi_write(40'h500, 0, 2'd1, 3'd4, 0, 0, 4'd6, 1'b0);
    axi_read(40'h500, 0, 2'd1, 3'd4, 0, 4'd6);
    check("strb_upper_kept", {32'h0, ref_mem[word_of(40'h500)][127:32]}, {32'h0, all_ones[127:32]});

    // 4: early wlast, slow B acceptance, then a fresh AW
    fill_payload(4, 1'b1);
    axi_write(40'h600, 3, 2'd1, 3'd4, 1, 5, 4'd7, 1'b0);
    axi_read(40'h600, 3, 2'd1, 3'd4, 0, 4'd7);
    fill_payload(1, 1'b1);
    axi_write(40'h700, 0, 2'd1, 3'd4, 0, 0, 4'd8, 1'b0);

    // 5: wrap at top of RAM, WRAP read, wrong size, missing wlast, FIXED
    fill_payload(2, 1'b1);
    axi_write(40'h3FF0, 1, 2'd1, 3'd4, 1, 0, 4'd9, 1'b0);
    axi_read(40'h3FF0, 1, 2'd1, 3'd4, 0, 4'd9);
    axi_read(40'h0, 0, 2'd1, 3'd4, 0, 4'd9);
    axi_read(40'h40, 3, 2'd2, 3'd4, 0, 4'd10);
    fill_payload(2, 1'b1);
    axi_write(40'h800, 1, 2'd1, 3'd3, 1, 0, 4'd11, 1'b0);
    fill_payload(3, 1'b1);
    axi_write(40'h900, 2, 2'd1, 3'd4, -1, 1, 4'd12, 1'b0);
    fill_payload(3, 1'b1);
    axi_write(40'hA00, 2, 2'd0, 3'd4, 2, 0, 4'd13, 1'b0);
    axi_read(40'hA00, 2, 2'd0, 3'd4, 0, 4'd13);

    // Concurrent AR and AW presented in the same cycle (disjoint regions)
    fill_payload(4, 1'b1);
    fork
      axi_write(40'h1000, 3, 2'd1, 3'd4, 3, 0, 4'd1, 1'b1);
      axi_read(40'h3000, 7, 2'd1, 3'd4, 2, 4'd2);
    join

    // 6: reset mid read burst
    s_axi_arid = 4'd4; s_axi_araddr = 40'h200; s_axi_arlen = 8'd15;
    s_axi_arburst = 2'd1; s_axi_arsize = 3'd4; s_axi_arvalid = 1'b1;
    tick();
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_rvalid", s_axi_rvalid, 0);
    check("midrst_arready", s_axi_arready, 1);
    check("midrst_rd_bursts", o_rd_bursts, 0);
    s_axi_rready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    ref_rd_bursts = 0;
    ref_wr_bursts = 0;
    tick();
    check("postrst_rvalid", s_axi_rvalid, 0);
    axi_read(40'h200, 3, 2'd1, 3'd4, 0, 4'd4);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] addr;
      logic [1:0] burst;
      logic [2:0] size;
      int len, wl;
      addr = {8'($urandom), $urandom};
      len = $urandom_range(0, 15);
      burst = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
      if ($urandom_range(0, 1) == 0) begin
        fill_payload(len + 1, 1'b0);
        wl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
        axi_write(addr, len, burst, size, wl, $urandom_range(0, 3), 4'($urandom), 1'b1);
      end else begin
        axi_read(addr, len, burst, size, 2, 4'($urandom));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
